// File: rtl/text_renderer.sv
// text_renderer: three-stage text-mode read pipeline turning pixel coordinates into
// char-buffer, font-ROM and palette reads, with ring-buffer scroll and blinking cursor.
module text_renderer #(
    parameter int COLS        = 80,
    parameter int BUF_ROWS    = 32,
    parameter int CURSOR_LINE = 14,
    parameter int BLINK_BIT   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [4:0]  start_row,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic [11:0] char_addr,
    input  logic [15:0] char_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  pal_fg_addr,
    output logic [3:0]  pal_bg_addr,
    input  logic [5:0]  pal_fg_data,
    input  logic [5:0]  pal_bg_data,
    output logic [5:0]  rgb_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    logic [6:0] col;
    logic [4:0] lrow, prow;
    logic       cursor_hit_d, pix_bit;
    logic [5:0] rgb_d;
    logic [2:0] x1_q, x2_q;
    logic [3:0] y1_q;
    logic       de1_q, hs1_q, vs1_q, cur1_q;
    logic       de2_q, hs2_q, vs2_q;
    logic [7:0] frame_cnt_q;
    logic       vs_prev_q;

    assign col  = pixel_x[9:3];
    assign lrow = pixel_y[8:4];
    assign prow = 5'((6'(start_row) + 6'(lrow)) % 6'(BUF_ROWS));
    assign char_addr = 12'(prow) * 12'(COLS) + 12'(col);
    assign cursor_hit_d = cursor_en & (lrow == cursor_row) & (col == cursor_col)
                        & (pixel_y[3:0] >= 4'(CURSOR_LINE)) & frame_cnt_q[BLINK_BIT];

    // Cursor cells render in inverse video by swapping the palette indices.
    assign font_addr   = {char_data[7:0], y1_q};
    assign pal_fg_addr = cur1_q ? char_data[15:12] : char_data[11:8];
    assign pal_bg_addr = cur1_q ? char_data[11:8]  : char_data[15:12];

    assign pix_bit = font_data[~x2_q];
    assign rgb_d   = de2_q ? (pix_bit ? pal_fg_data : pal_bg_data) : 6'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1_q        <= '0;
            y1_q        <= '0;
            de1_q       <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            cur1_q      <= 1'b0;
            x2_q        <= '0;
            de2_q       <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            rgb_out     <= '0;
            de_out      <= 1'b0;
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            frame_cnt_q <= '0;
            vs_prev_q   <= 1'b0;
        end else begin
            x1_q        <= pixel_x[2:0];
            y1_q        <= pixel_y[3:0];
            de1_q       <= de_in;
            hs1_q       <= hsync_in;
            vs1_q       <= vsync_in;
            cur1_q      <= cursor_hit_d;
            x2_q        <= x1_q;
            de2_q       <= de1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            rgb_out     <= rgb_d;
            de_out      <= de2_q;
            hsync_out   <= hs2_q;
            vsync_out   <= vs2_q;
            frame_cnt_q <= frame_cnt_q + 8'(vsync_in & ~vs_prev_q);
            vs_prev_q   <= vsync_in;
        end
    end
endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: table-driven, directed and randomized checks of text_renderer
// against a coordinate-level reference model with 1-cycle memory models.
module tb_text_renderer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [4:0]  start_row = '0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic        cursor_en = 1'b0;
    logic [11:0] char_addr, font_addr;
    logic [15:0] char_data = '0;
    logic [7:0]  font_data = '0;
    logic [3:0]  pal_fg_addr, pal_bg_addr;
    logic [5:0]  pal_fg_data = '0, pal_bg_data = '0;
    logic [5:0]  rgb_out;
    logic        de_out, hsync_out, vsync_out;

    logic [15:0] cbuf [4096];
    logic [7:0]  font [4096];
    logic [5:0]  pal  [16];

    int compared = 0;
    int failed = 0;
    int fc = 0;
    logic vsp = 1'b0;
    logic [8:0] expq [$];
    logic [8:0] obs  [$];

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [4:0]  sr;
        logic [11:0] addr;
    } addr_vec_t;
    addr_vec_t av [6];
    logic [5:0] exp_a [8];

    text_renderer dut (
        .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .start_row(start_row), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cursor_en(cursor_en), .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .pal_fg_addr(pal_fg_addr), .pal_bg_addr(pal_bg_addr),
        .pal_fg_data(pal_fg_data), .pal_bg_data(pal_bg_data),
        .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        char_data   <= cbuf[char_addr];
        font_data   <= font[font_addr];
        pal_fg_data <= pal[pal_fg_addr];
        pal_bg_data <= pal[pal_bg_addr];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int model_addr();
        int prow;
        prow = (int'(start_row) + (int'(pixel_y) / 16) % 32) % 32;
        return prow * 80 + int'(pixel_x) / 8;
    endfunction

    function automatic logic [8:0] model_pix();
        int col, lrow, line, fgi, bgi, tmp;
        logic [15:0] ch;
        logic hit, b;
        col  = int'(pixel_x) / 8;
        lrow = (int'(pixel_y) / 16) % 32;
        line = int'(pixel_y) % 16;
        ch   = cbuf[model_addr()];
        hit  = cursor_en && lrow == int'(cursor_row) && col == int'(cursor_col)
               && line >= 14 && ((fc / 16) % 2 == 1);
        fgi  = int'(ch[11:8]);
        bgi  = int'(ch[15:12]);
        if (hit) begin
            tmp = fgi; fgi = bgi; bgi = tmp;
        end
        b = font[int'(ch[7:0]) * 16 + line][7 - int'(pixel_x) % 8];
        return {de_in, hsync_in, vsync_in, de_in ? (b ? pal[fgi] : pal[bgi]) : 6'd0};
    endfunction

    task automatic drive(input int x, input int y, input logic de, input logic hs, input logic vs);
        pixel_x = 10'(x); pixel_y = 10'(y); de_in = de; hsync_in = hs; vsync_in = vs;
    endtask

    // One clock: check the combinational address, predict, advance, compare the 3-deep output.
    task automatic step();
        logic [8:0] e;
        #1;
        chk("char_addr", 32'(char_addr), 32'(model_addr()));
        @(posedge clk);
        expq.push_back(model_pix());
        if (vsync_in && !vsp) fc = (fc + 1) % 256;
        vsp = vsync_in;
        #1;
        obs.push_back({de_out, hsync_out, vsync_out, rgb_out});
        if (expq.size() >= 3) begin
            e = expq.pop_front();
            chk("pipe {de,hs,vs,rgb}", 32'(obs[$]), 32'(e));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_async", 32'({de_out, hsync_out, vsync_out, rgb_out}), 32'd0);
        expq.delete();
        fc = 0;
        vsp = 1'b0;
        repeat (3) begin
            drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom), 1'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            chk("rst_hold", 32'({de_out, hsync_out, vsync_out, rgb_out}), 32'd0);
        end
        reset_n = 1'b1;
        expq.push_back('0);
        expq.push_back('0);
    endtask

    task automatic vs_pulses(input int n);
        repeat (n) begin
            drive(0, 0, 1'b0, 1'b0, 1'b1); step();
            drive(0, 0, 1'b0, 1'b0, 1'b0); step();
        end
    endtask

    initial begin
        av[0] = '{x: 10'd0,   y: 10'd0,   sr: 5'd0,  addr: 12'd0};
        av[1] = '{x: 10'd0,   y: 10'd16,  sr: 5'd31, addr: 12'd0};
        av[2] = '{x: 10'd639, y: 10'd479, sr: 5'd31, addr: 12'd2319};
        av[3] = '{x: 10'd8,   y: 10'd16,  sr: 5'd0,  addr: 12'd81};
        av[4] = '{x: 10'd639, y: 10'd479, sr: 5'd0,  addr: 12'd2399};
        av[5] = '{x: 10'd100, y: 10'd200, sr: 5'd5,  addr: 12'd1372};
        exp_a = '{6'b111111, 6'b110000, 6'b110000, 6'b111111,
                  6'b111111, 6'b110000, 6'b110000, 6'b111111};
        for (int i = 0; i < 4096; i++) begin
            cbuf[i] = 16'h0720;
            font[i] = 8'h00;
        end
        for (int i = 0; i < 16; i++) pal[i] = 6'(i * 5 + 3);
        pal[0] = 6'b000000; pal[1] = 6'b111111; pal[4] = 6'b110000; pal[7] = 6'b110011;

        #2;
        do_reset();
        obs.delete();
        drive(0, 0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("addr_after_reset", 32'(char_addr), 32'd0);
        step();
        idle(3);
        chk("de_lat_2", 32'(obs[1][8]), 32'd0);
        chk("de_lat_3", 32'(obs[2][8]), 32'd1);

        for (int i = 0; i < 6; i++) begin
            drive(int'(av[i].x), int'(av[i].y), 1'b0, 1'b0, 1'b0);
            start_row = av[i].sr;
            #1;
            chk($sformatf("addr_vec%0d", i), 32'(char_addr), 32'(av[i].addr));
            step();
        end
        start_row = '0;

        repeat (300) begin
            drive($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0, 1'b0);
            step();
            chk("blank_frame", 32'(obs[$][5:0]), 32'd0);
        end

        idle(3);
        cbuf[0] = 16'h1441;
        font[16'h41 * 16 + 5] = 8'b01100110;
        obs.delete();
        for (int x = 0; x < 8; x++) begin
            drive(x, 5, 1'b1, 1'b0, 1'b0);
            step();
        end
        idle(3);
        for (int x = 0; x < 8; x++) chk($sformatf("colour_x%0d", x), 32'(obs[x + 2][5:0]), 32'(exp_a[x]));
        cbuf[0] = 16'h0720;

        do_reset();
        cursor_en = 1'b1; cursor_col = '0; cursor_row = '0;
        vs_pulses(16);
        obs.delete();
        drive(0, 14, 1'b1, 1'b0, 1'b0); step();
        drive(0, 13, 1'b1, 1'b0, 1'b0); step();
        idle(3);
        chk("cursor_on_l14", 32'(obs[2][5:0]), 32'b110011);
        chk("cursor_on_l13", 32'(obs[3][5:0]), 32'd0);
        vs_pulses(16);
        obs.delete();
        drive(0, 14, 1'b1, 1'b0, 1'b0); step();
        idle(3);
        chk("cursor_off_l14", 32'(obs[2][5:0]), 32'd0);
        cursor_row = 5'd31; cursor_col = 7'd127;
        drive(1016, 510, 1'b1, 1'b0, 1'b0); step();
        cursor_en = 1'b0;

        obs.delete();
        repeat (40) begin
            drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 1'($urandom), 1'($urandom));
            step();
        end
        idle(3);

        for (int i = 0; i < 4096; i++) begin
            cbuf[i] = 16'($urandom);
            font[i] = 8'($urandom);
        end
        for (int i = 0; i < 16; i++) pal[i] = 6'($urandom);
        for (int n = 0; n < 3000; n++) begin
            int px, py;
            px = $urandom_range(0, 1023);
            py = $urandom_range(0, 1023);
            if ($urandom_range(0, 2) == 0) begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 15) | 14;
            end
            drive(px, py, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0 ? ~hsync_in : hsync_in,
                  $urandom_range(0, 5) == 0 ? ~vsync_in : vsync_in);
            start_row = 5'($urandom);
            cursor_en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 1) == 1) begin
                cursor_col = pixel_x[9:3];
                cursor_row = pixel_y[8:4];
            end else begin
                cursor_col = 7'($urandom);
                cursor_row = 5'($urandom);
            end
            if (n == 1500) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/text_renderer.md
Name: text_renderer

Overview:
Read-side pipeline for text mode.
- Converts the current pixel coordinate into a character-buffer port-B read, then a font ROM lookup, then a foreground/background palette lookup.
- Emits one 6-bit RGB pixel per clock, with sync and display-enable delayed to match.
- Sits between the video timing generator and the DAC output mux, in the 25.175MHz video domain.
- Handles ring-buffer scrolling via a start-row offset and draws a blinking underline cursor.

Parameters:
COLS, 80, characters per row; buffer row stride.
BUF_ROWS, 32, physical rows in the ring buffer (COLS*BUF_ROWS = 2560).
CURSOR_LINE, 14, first glyph scanline (0-15) of the cursor bar.
BLINK_BIT, 4, frame-counter bit that drives the cursor blink (16 frames on, 16 off).

Ports:
clk  in  1  video pixel clock; single clock domain.
reset_n  in  1  asynchronous active-low reset.
pixel_x  in  10  current pixel column, 0-639.
pixel_y  in  10  current pixel row, 0-479.
de_in  in  1  display enable from the timing generator.
hsync_in  in  1  horizontal sync from the timing generator.
vsync_in  in  1  vertical sync from the timing generator.
start_row  in  5  physical buffer row shown at the top of the screen.
cursor_col  in  7  cursor column, 0-79.
cursor_row  in  5  cursor logical (on-screen) row, 0-29.
cursor_en  in  1  cursor display enable.
char_addr  out  12  character buffer port-B address.
char_data  in  16  character buffer port-B data {attr[7:0], code[7:0]}; valid 1 cycle after address.
font_addr  out  12  font ROM address {code, scanline}.
font_data  in  8  font ROM row; valid 1 cycle after address; bit 7 is the leftmost pixel.
pal_fg_addr  out  4  palette read address A (foreground).
pal_bg_addr  out  4  palette read address B (background).
pal_fg_data  in  6  palette data A; valid 1 cycle after address.
pal_bg_data  in  6  palette data B; valid 1 cycle after address.
rgb_out  out  6  pixel colour {R[1:0], G[1:0], B[1:0]}.
de_out  out  1  de_in delayed 3 cycles.
hsync_out  out  1  hsync_in delayed 3 cycles.
vsync_out  out  1  vsync_in delayed 3 cycles.

Behaviour:
- Reset (asynchronous, active low): all pipeline registers clear; rgb_out = 0, de_out = 0, hsync_out = 0, vsync_out = 0, frame counter = 0. Address outputs are combinational, so they follow the inputs and cleared registers.
- Cycle T (S0, address generation):
  - col = pixel_x[9:3]; lrow = pixel_y[8:4].
  - prow = (start_row + lrow) mod BUF_ROWS, a 5-bit wrap.
  - char_addr = prow*COLS + col, combinational from the inputs.
  - Register x[2:0], y[3:0], de, hsync, vsync and cursor_hit into stage 1.
  - cursor_hit = cursor_en & (lrow == cursor_row) & (col == cursor_col) & (pixel_y[3:0] >= CURSOR_LINE) & frame_cnt[BLINK_BIT].
- Cycle T+1 (S1, glyph and palette fetch):
  - font_addr = {char_data[7:0], y1[3:0]}.
  - pal_fg_addr = char_data[11:8]; pal_bg_addr = char_data[15:12].
  - If cursor_hit1 is set, fg and bg addresses are swapped.
  - All three addresses are combinational from char_data and stage-1 registers.
  - Forward x, de, hsync and vsync to stage 2.
- Cycle T+2 (S2, pixel select):
  - bit = font_data[7 - x2[2:0]].
  - rgb_out <= de2 ? (bit ? pal_fg_data : pal_bg_data) : 6'b0.
  - de/hsync/vsync outputs register alongside rgb_out, so rgb_out is valid at T+3.
  - Latency is exactly 3 clocks for every output; throughput is 1 pixel/clock with no stalls.
- Frame counter: 8-bit; increments on every 0->1 transition of vsync_in (edge detected against a registered copy); wraps 255 -> 0.
- Boundaries:
  - start_row + lrow ≥ 32 wraps to row 0, e.g. start_row=31, lrow=1 gives prow=0.
  - pixel_x/pixel_y outside the active area, or de_in=0: address outputs are still driven, but rgb_out is forced to 0.
  - cursor_row/cursor_col out of range: the cursor never matches and nothing is drawn.
  - start_row or cursor changes mid-frame take effect on the next pixel; no line buffering.
  - reset_n asserted mid-line: outputs clear immediately; the pipeline refills after 3 clocks of valid input.

Test Plan:
- Bench models: character buffer, font ROM and palette are 1-cycle-latency models; the buffer initialises to 0x0720 and the palette to its default values.
- Reset: hold reset_n=0 with random inputs -> rgb_out=0, de_out=0, hsync_out=0, vsync_out=0. Release and drive de_in=1, pixel (0,0) -> char_addr=0; de_out=1 exactly 3 clocks later.
- Default buffer 0x0720: full frame with de_in=1 -> rgb_out=000000 at all pixels (space glyph, bg=palette[0]).
- Colour select: buffer[0]=0x1441 ('A', fg=4, bg=1), font row 5 of 'A' = 8'b01100110, pixel_y=5, pixel_x=0..7 -> rgb_out = 111111,110000,110000,111111,111111,110000,110000,111111.
- Scroll wrap: start_row=31, pixel (0,16) -> char_addr=0. Same start_row, pixel (639,479) -> char_addr = 28*80+79 = 2319.
- Cursor blink: cursor_en=1, cursor (0,0), buffer[0]=0x0720, scanline 14 -> rgb_out=palette[7]=110011 when frame_cnt[4]=1, 000000 when frame_cnt[4]=0. Scanline 13 is always 000000.
- Sync alignment: toggle hsync_in/vsync_in arbitrarily with de_in=0 -> outputs equal the inputs delayed by exactly 3 clocks; rgb_out stays 0.
